brick_field_renderer: RTL and testbench

// Parametrised successor of the game-screen renderer. It draws the housing, paddle, ball and a

---
 rtl/brick_field_renderer.sv | 251 +++++++++++++++++++++++++
 tb/tb_brick_field_renderer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_field_renderer.sv
// Purpose: draws housing, paddle, ball and a ROWSxCOLS brick wall; owns the brick bitmap and its clear/restore port.
// Latency: COLOR follows X/Y by 2 clocks; FRAME_DONE pulses 1 clock after the frame-boundary sample.
// Backpressure: BRICK_CLEAR_READY is high only in vertical blank, with no refill pending and RESET low.
module brick_field_renderer #(
  parameter int unsigned SCREEN_H            = 600,
  parameter int unsigned CEILING_Y_TILE      = 9,
  parameter int unsigned LEFT_WALL_X_TILE    = 0,
  parameter int unsigned RIGHT_WALL_X_TILE   = 99,
  parameter int unsigned PADDLE_Y_TILE       = 73,
  parameter int unsigned PADDLE_LENGTH_PIXEL = 60,
  parameter int unsigned BALL_SIZE_PIXEL     = 8,
  parameter int unsigned BRICK_ROWS          = 6,
  parameter int unsigned BRICK_COLS          = 14,
  parameter int unsigned BRICK_W_PIXEL       = 56,
  parameter int unsigned BRICK_H_PIXEL       = 16,
  parameter int unsigned BRICK_LEFT_X_PIXEL  = 8,
  parameter int unsigned BRICK_TOP_Y_PIXEL   = 120,
  parameter int unsigned BRICK_COLOR_BASE    = 8'hE0,
  parameter int unsigned BRICK_COLOR_STEP    = 8'hF5,
  parameter int unsigned BALL_COLOR          = 8'h1F
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] X_PIXEL,
  input  logic [9:0] Y_PIXEL,
  input  logic [9:0] PADDLE_X_PIXEL,
  input  logic [9:0] BALL_X_PIXEL,
  input  logic [9:0] BALL_Y_PIXEL,
  input  logic       BALL_VISIBLE,
  input  logic       BRICK_CLEAR_VALID,
  input  logic [2:0] BRICK_CLEAR_ROW,
  input  logic [3:0] BRICK_CLEAR_COL,
  output logic       BRICK_CLEAR_READY,
  input  logic       BRICKS_RESTORE,
  input  logic [2:0] BRICK_QUERY_ROW,
  input  logic [3:0] BRICK_QUERY_COL,
  output logic       BRICK_QUERY_PRESENT,
  output logic [7:0] BRICKS_REMAINING,
  output logic [7:0] COLOR,
  output logic       FRAME_DONE
);

  localparam logic [6:0] CEIL_T    = 7'(CEILING_Y_TILE);
  localparam logic [6:0] LWALL_T   = 7'(LEFT_WALL_X_TILE);
  localparam logic [6:0] RWALL_T   = 7'(RIGHT_WALL_X_TILE);
  localparam logic [6:0] PADDLE_T  = 7'(PADDLE_Y_TILE);
  localparam logic [9:0] SCREEN_HV = 10'(SCREEN_H);
  localparam logic [7:0] FULL_CNT  = 8'(BRICK_ROWS * BRICK_COLS);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } restore_state_t;

  // Shadowed game state, only updated at the frame boundary
  logic [9:0] paddle_x_q, paddle_x_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [9:0] ball_y_q, ball_y_d;
  logic       ball_vis_q, ball_vis_d;
  logic       frame_done_q, frame_done_d;

  // Stage 1 hit flags
  logic       house_q, house_d;
  logic       ball_hit_q, ball_hit_d;
  logic       paddle_hit_q, paddle_hit_d;
  logic       brick_hit_q, brick_hit_d;
  logic [7:0] brick_color_q, brick_color_d;

  // Stage 2 colour
  logic [7:0] color_q, color_d;

  // Brick wall state
  restore_state_t                         state_q, state_d;
  logic [BRICK_ROWS-1:0][BRICK_COLS-1:0]  bitmap_q, bitmap_d;
  logic [7:0]                             remaining_q, remaining_d;

  logic        frame_edge;
  logic [6:0]  x_tile, y_tile;
  logic [31:0] x32, y32;
  logic [10:0] x11, y11;
  logic [10:0] paddle_end, ball_x_end, ball_y_end;
  logic        row_hit, col_hit;
  logic [2:0]  row_idx;
  logic [3:0]  col_idx;
  logic [7:0]  row_color;
  logic        clear_fire, clear_in_range, query_in_range;

  assign frame_edge = (X_PIXEL == 10'd0) && (Y_PIXEL == SCREEN_HV);
  assign x_tile     = X_PIXEL[9:3];
  assign y_tile     = Y_PIXEL[9:3];
  assign x32        = {22'd0, X_PIXEL};
  assign y32        = {22'd0, Y_PIXEL};
  assign x11        = {1'b0, X_PIXEL};
  assign y11        = {1'b0, Y_PIXEL};

  // Right/bottom edges are computed one bit wider so objects near 1023 never wrap to x/y near 0
  assign paddle_end = {1'b0, paddle_x_q} + 11'(PADDLE_LENGTH_PIXEL);
  assign ball_x_end = {1'b0, ball_x_q} + 11'(BALL_SIZE_PIXEL);
  assign ball_y_end = {1'b0, ball_y_q} + 11'(BALL_SIZE_PIXEL);

  // Shadow registers reload on the frame-boundary sample; FRAME_DONE marks the cycle after it
  always_comb begin
    paddle_x_d   = paddle_x_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    ball_vis_d   = ball_vis_q;
    frame_done_d = frame_edge;
    if (frame_edge) begin
      paddle_x_d = PADDLE_X_PIXEL;
      ball_x_d   = BALL_X_PIXEL;
      ball_y_d   = BALL_Y_PIXEL;
      ball_vis_d = BALL_VISIBLE;
    end
  end

  // Locate the brick cell under the pixel, excluding the mortar column/row of each brick
  always_comb begin
    row_hit   = 1'b0;
    col_hit   = 1'b0;
    row_idx   = 3'd0;
    col_idx   = 4'd0;
    row_color = 8'd0;
    for (int r = 0; r < BRICK_ROWS; r++) begin
      if ((y32 >= BRICK_TOP_Y_PIXEL + r * BRICK_H_PIXEL) &&
          (y32 <  BRICK_TOP_Y_PIXEL + (r + 1) * BRICK_H_PIXEL - 1)) begin
        row_hit   = 1'b1;
        row_idx   = 3'(r);
        row_color = 8'(BRICK_COLOR_BASE + r * BRICK_COLOR_STEP);
      end
    end
    for (int c = 0; c < BRICK_COLS; c++) begin
      if ((x32 >= BRICK_LEFT_X_PIXEL + c * BRICK_W_PIXEL) &&
          (x32 <  BRICK_LEFT_X_PIXEL + (c + 1) * BRICK_W_PIXEL - 1)) begin
        col_hit = 1'b1;
        col_idx = 4'(c);
      end
    end
  end

  // Stage 1: per-object hit tests against the current pixel and the shadowed positions
  always_comb begin
    house_d       = (y_tile == CEIL_T) ||
                    (((x_tile == LWALL_T) || (x_tile == RWALL_T)) && (y_tile >= CEIL_T));
    paddle_hit_d  = (y_tile == PADDLE_T) && (x11 >= {1'b0, paddle_x_q}) && (x11 < paddle_end);
    ball_hit_d    = ball_vis_q &&
                    (x11 >= {1'b0, ball_x_q}) && (x11 < ball_x_end) &&
                    (y11 >= {1'b0, ball_y_q}) && (y11 < ball_y_end);
    brick_hit_d   = 1'b0;
    brick_color_d = row_color;
    if (row_hit && col_hit) begin
      brick_hit_d = bitmap_q[row_idx][col_idx];
    end
  end

  // Stage 2: resolve drawing priority into the output colour
  always_comb begin
    color_d = 8'h00;
    if (house_q) begin
      color_d = 8'hFF;
    end else if (ball_hit_q) begin
      color_d = 8'(BALL_COLOR);
    end else if (paddle_hit_q) begin
      color_d = 8'hFF;
    end else if (brick_hit_q) begin
      color_d = brick_color_q;
    end
  end

  assign clear_in_range = ({29'd0, BRICK_CLEAR_ROW} < BRICK_ROWS) &&
                          ({28'd0, BRICK_CLEAR_COL} < BRICK_COLS);
  assign query_in_range = ({29'd0, BRICK_QUERY_ROW} < BRICK_ROWS) &&
                          ({28'd0, BRICK_QUERY_COL} < BRICK_COLS);

  // Restore FSM plus clear port: clears only in vblank while idle, refill lands on the frame edge
  always_comb begin
    state_d           = state_q;
    bitmap_d          = bitmap_q;
    remaining_d       = remaining_q;
    BRICK_CLEAR_READY = (Y_PIXEL >= SCREEN_HV) && (state_q == ST_IDLE) && !RESET;
    clear_fire        = BRICK_CLEAR_VALID && BRICK_CLEAR_READY;
    case (state_q)
      ST_IDLE: begin
        if (clear_fire && clear_in_range && bitmap_q[BRICK_CLEAR_ROW][BRICK_CLEAR_COL]) begin
          bitmap_d[BRICK_CLEAR_ROW][BRICK_CLEAR_COL] = 1'b0;
          remaining_d = remaining_q - 8'd1;
        end
        if (BRICKS_RESTORE) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_edge) begin
          state_d     = ST_IDLE;
          bitmap_d    = '1;
          remaining_d = FULL_CNT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Combinational bitmap lookup for the game logic
  always_comb begin
    BRICK_QUERY_PRESENT = 1'b0;
    if (query_in_range) begin
      BRICK_QUERY_PRESENT = bitmap_q[BRICK_QUERY_ROW][BRICK_QUERY_COL];
    end
  end

  // All state registers; reset returns every flop to its power-up value immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      paddle_x_q    <= 10'd0;
      ball_x_q      <= 10'd0;
      ball_y_q      <= 10'd0;
      ball_vis_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      house_q       <= 1'b0;
      ball_hit_q    <= 1'b0;
      paddle_hit_q  <= 1'b0;
      brick_hit_q   <= 1'b0;
      brick_color_q <= 8'd0;
      color_q       <= 8'd0;
      state_q       <= ST_IDLE;
      bitmap_q      <= '1;
      remaining_q   <= FULL_CNT;
    end else begin
      paddle_x_q    <= paddle_x_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      ball_vis_q    <= ball_vis_d;
      frame_done_q  <= frame_done_d;
      house_q       <= house_d;
      ball_hit_q    <= ball_hit_d;
      paddle_hit_q  <= paddle_hit_d;
      brick_hit_q   <= brick_hit_d;
      brick_color_q <= brick_color_d;
      color_q       <= color_d;
      state_q       <= state_d;
      bitmap_q      <= bitmap_d;
      remaining_q   <= remaining_d;
    end
  end

  assign COLOR            = color_q;
  assign FRAME_DONE       = frame_done_q;
  assign BRICKS_REMAINING = remaining_q;

endmodule

// File: tb/tb_brick_field_renderer.sv
// Purpose: self-checking bench for brick_field_renderer (pixel table, shadows, clear port, restore, reset).
// Latency: pixel expectations are queued at drive time and compared 2 clocks later.
// Backpressure: clear-port READY is checked combinationally before each edge.
module tb_brick_field_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_pix, y_pix, paddle_x, ball_x, ball_y;
  logic       ball_vis;
  logic       clr_vld;
  logic [2:0] clr_row;
  logic [3:0] clr_col;
  logic       clr_rdy;
  logic       restore;
  logic [2:0] q_row;
  logic [3:0] q_col;
  logic       q_present;
  logic [7:0] remaining;
  logic [7:0] color;
  logic       frame_done;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       chk;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] exp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] exp;
  } vec_t;
  localparam int NV = 24;
  vec_t tbl[NV];

  brick_field_renderer dut (
    .CLK                 (clk),
    .RESET               (rst),
    .X_PIXEL             (x_pix),
    .Y_PIXEL             (y_pix),
    .PADDLE_X_PIXEL      (paddle_x),
    .BALL_X_PIXEL        (ball_x),
    .BALL_Y_PIXEL        (ball_y),
    .BALL_VISIBLE        (ball_vis),
    .BRICK_CLEAR_VALID   (clr_vld),
    .BRICK_CLEAR_ROW     (clr_row),
    .BRICK_CLEAR_COL     (clr_col),
    .BRICK_CLEAR_READY   (clr_rdy),
    .BRICKS_RESTORE      (restore),
    .BRICK_QUERY_ROW     (q_row),
    .BRICK_QUERY_COL     (q_col),
    .BRICK_QUERY_PRESENT (q_present),
    .BRICKS_REMAINING    (remaining),
    .COLOR               (color),
    .FRAME_DONE          (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // One pixel clock: present X/Y, queue the expectation, compare what left the pipe
  task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic c, input logic [7:0] e);
    sb_t ent;
    x_pix = x;
    y_pix = y;
    sb.push_back('{c, x, y, e});
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      ent = sb.pop_front();
      if (ent.chk) begin
        vectors++;
        if (color !== ent.exp) begin
          miscompares++;
          $display("FAIL color(%0d,%0d): got %02h expected %02h", ent.x, ent.y, color, ent.exp);
        end
      end
    end
  endtask

  task automatic frame_edge();
    drive(10'd0, 10'd600, 1'b0, 8'h00);
    chk("frame_done pulse", 8'(frame_done), 8'h01);
    drive(10'd1, 10'd600, 1'b0, 8'h00);
    chk("frame_done drop", 8'(frame_done), 8'h00);
  endtask

  task automatic query(input logic [2:0] r, input logic [3:0] c, input logic e, input string name);
    q_row = r;
    q_col = c;
    #1;
    chk(name, 8'(q_present), 8'(e));
  endtask

  task automatic ready_is(input logic [9:0] y, input logic e, input string name);
    x_pix = 10'd5;
    y_pix = y;
    #1;
    chk(name, 8'(clr_rdy), 8'(e));
  endtask

  initial begin
    // Pixel expectations with reset shadows (paddle at x=0, ball hidden) and a full wall
    tbl[0]  = '{10'd0,   10'd72,  8'hFF};   // ceiling
    tbl[1]  = '{10'd400, 10'd300, 8'h00};   // background
    tbl[2]  = '{10'd8,   10'd120, 8'hE0};   // brick (0,0)
    tbl[3]  = '{10'd63,  10'd120, 8'h00};   // mortar column of (0,0)
    tbl[4]  = '{10'd64,  10'd120, 8'hE0};   // brick (0,1)
    tbl[5]  = '{10'd8,   10'd135, 8'h00};   // mortar row of row 0
    tbl[6]  = '{10'd8,   10'd136, 8'hD5};   // row 1
    tbl[7]  = '{10'd120, 10'd152, 8'hCA};   // brick (2,2)
    tbl[8]  = '{10'd8,   10'd168, 8'hBF};   // row 3
    tbl[9]  = '{10'd8,   10'd184, 8'hB4};   // row 4
    tbl[10] = '{10'd8,   10'd200, 8'hA9};   // row 5
    tbl[11] = '{10'd8,   10'd215, 8'h00};   // mortar row of row 5
    tbl[12] = '{10'd8,   10'd216, 8'h00};   // below the wall
    tbl[13] = '{10'd790, 10'd120, 8'hE0};   // brick (0,13)
    tbl[14] = '{10'd791, 10'd120, 8'h00};   // mortar column of (0,13)
    tbl[15] = '{10'd792, 10'd120, 8'hFF};   // right wall
    tbl[16] = '{10'd0,   10'd40,  8'h00};   // wall column above ceiling
    tbl[17] = '{10'd400, 10'd79,  8'hFF};   // last ceiling line
    tbl[18] = '{10'd400, 10'd80,  8'h00};   // first line under ceiling
    tbl[19] = '{10'd30,  10'd588, 8'hFF};   // paddle
    tbl[20] = '{10'd59,  10'd588, 8'hFF};   // paddle last px
    tbl[21] = '{10'd60,  10'd588, 8'h00};   // one past paddle
    tbl[22] = '{10'd7,   10'd300, 8'hFF};   // left wall
    tbl[23] = '{10'd799, 10'd583, 8'hFF};   // right wall low

    rst = 1'b1;
    x_pix = 10'd5; y_pix = 10'd600;
    paddle_x = 10'd0; ball_x = 10'd0; ball_y = 10'd0; ball_vis = 1'b0;
    clr_vld = 1'b0; clr_row = 3'd0; clr_col = 4'd0; restore = 1'b0;
    q_row = 3'd0; q_col = 4'd0;

    // Reset state
    #12;
    chk("reset color", color, 8'h00);
    chk("reset frame_done", 8'(frame_done), 8'h00);
    chk("reset ready", 8'(clr_rdy), 8'h00);
    chk("reset remaining", remaining, 8'd84);
    query(3'd0, 4'd0, 1'b1, "reset query(0,0)");
    query(3'd5, 4'd13, 1'b1, "reset query(5,13)");
    query(3'd7, 4'd15, 1'b0, "reset query(7,15)");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();

    // Static scene
    for (int i = 0; i < NV; i++) drive(tbl[i].x, tbl[i].y, 1'b1, tbl[i].exp);

    // Paddle near the right limit must not wrap; ball appears after the frame edge
    paddle_x = 10'd1000; ball_x = 10'd200; ball_y = 10'd300; ball_vis = 1'b1;
    frame_edge();
    drive(10'd10,  10'd584, 1'b1, 8'h00);
    drive(10'd20,  10'd588, 1'b1, 8'h00);
    drive(10'd35,  10'd591, 1'b1, 8'h00);
    drive(10'd39,  10'd586, 1'b1, 8'h00);
    drive(10'd700, 10'd588, 1'b1, 8'h00);
    drive(10'd791, 10'd588, 1'b1, 8'h00);
    drive(10'd200, 10'd300, 1'b1, 8'h1F);
    drive(10'd207, 10'd307, 1'b1, 8'h1F);
    drive(10'd208, 10'd300, 1'b1, 8'h00);
    drive(10'd200, 10'd308, 1'b1, 8'h00);
    drive(10'd199, 10'd300, 1'b1, 8'h00);
    drive(10'd203, 10'd299, 1'b1, 8'h00);

    // Mid-frame ball move is held off until the next frame
    ball_x = 10'd400;
    drive(10'd200, 10'd300, 1'b1, 8'h1F);
    drive(10'd400, 10'd300, 1'b1, 8'h00);
    frame_edge();
    drive(10'd400, 10'd300, 1'b1, 8'h1F);
    drive(10'd200, 10'd300, 1'b1, 8'h00);
    drive(10'd400, 10'd10,  1'b0, 8'h00);

    // Clear port: refused in active video, accepted in vblank, repeat and out-of-range harmless
    clr_vld = 1'b1; clr_row = 3'd2; clr_col = 4'd3;
    ready_is(10'd300, 1'b0, "ready active video");
    drive(10'd5, 10'd300, 1'b0, 8'h00);
    chk("remaining after refused clear", remaining, 8'd84);
    query(3'd2, 4'd3, 1'b1, "query(2,3) held");
    ready_is(10'd600, 1'b1, "ready vblank");
    drive(10'd5, 10'd600, 1'b0, 8'h00);
    chk("remaining after clear", remaining, 8'd83);
    query(3'd2, 4'd3, 1'b0, "query(2,3) cleared");
    drive(10'd5, 10'd600, 1'b0, 8'h00);
    chk("remaining after repeat clear", remaining, 8'd83);
    clr_row = 3'd7; clr_col = 4'd15;
    ready_is(10'd600, 1'b1, "ready out-of-range");
    drive(10'd5, 10'd600, 1'b0, 8'h00);
    clr_vld = 1'b0;
    chk("remaining after out-of-range clear", remaining, 8'd83);
    query(3'd7, 4'd15, 1'b0, "query(7,15)");
    drive(10'd176, 10'd152, 1'b1, 8'h00);
    drive(10'd232, 10'd152, 1'b1, 8'hCA);
    drive(10'd174, 10'd152, 1'b1, 8'hCA);
    drive(10'd175, 10'd152, 1'b1, 8'h00);

    // Restore: clear 5 more, pulse restore in active video, refill lands on frame edge
    for (int c = 0; c < 5; c++) begin
      clr_vld = 1'b1; clr_row = 3'd0; clr_col = 4'(c);
      drive(10'd5, 10'd600, 1'b0, 8'h00);
    end
    clr_vld = 1'b0;
    chk("remaining after five clears", remaining, 8'd78);
    restore = 1'b1;
    drive(10'd5, 10'd10, 1'b0, 8'h00);
    restore = 1'b0;
    ready_is(10'd600, 1'b0, "ready while pending");
    clr_vld = 1'b1; clr_row = 3'd0; clr_col = 4'd5;
    drive(10'd5, 10'd600, 1'b0, 8'h00);
    clr_vld = 1'b0;
    chk("remaining pending clear ignored", remaining, 8'd78);
    query(3'd0, 4'd0, 1'b0, "query(0,0) before refill");
    frame_edge();
    chk("remaining after refill", remaining, 8'd84);
    query(3'd0, 4'd0, 1'b1, "query(0,0) refilled");
    query(3'd2, 4'd3, 1'b1, "query(2,3) refilled");
    ready_is(10'd600, 1'b1, "ready after refill");
    drive(10'd8, 10'd120, 1'b1, 8'hE0);

    // Reset in the middle of a line
    clr_vld = 1'b1; clr_row = 3'd1; clr_col = 4'd1;
    drive(10'd5, 10'd600, 1'b0, 8'h00);
    clr_vld = 1'b0;
    chk("remaining before reset", remaining, 8'd83);
    drive(10'd8, 10'd120, 1'b1, 8'hE0);
    drive(10'd8, 10'd120, 1'b1, 8'hE0);
    chk("color before reset", color, 8'hE0);
    #2;
    rst = 1'b1;
    x_pix = 10'd5; y_pix = 10'd600;
    #1;
    chk("color in reset", color, 8'h00);
    chk("remaining in reset", remaining, 8'd84);
    chk("ready in reset", 8'(clr_rdy), 8'h00);
    query(3'd1, 4'd1, 1'b1, "query(1,1) in reset");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(10'd8, 10'd120, 1'b1, 8'hE0);
    chk("color first edge after reset", color, 8'h00);
    drive(10'd400, 10'd300, 1'b1, 8'h00);   // ball shadow cleared by reset
    drive(10'd30,  10'd588, 1'b1, 8'hFF);   // paddle shadow back at 0
    drive(10'd400, 10'd10,  1'b0, 8'h00);
    drive(10'd400, 10'd10,  1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
